// File: rtl/next_line_prefetcher.sv
// rtl/next_line_prefetcher.sv - next-line instruction prefetcher with one-line stream buffer
//
// Forwards icache line misses to the arbiter's demand port. After every demand
// fill or buffer hit, it fetches line N+PF_DISTANCE through the prefetch port
// into a single-line stream buffer. A later miss that matches the buffered line
// is answered from the buffer and does not access memory.
//
// Optional feature: define NLP_STATS_EN to add the saturating hit/miss counters
// stat_hits and stat_misses.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ic_read/ic_address       icache miss request (held until ic_resp)
//   ic_resp/ic_rdata         one-cycle response and line data to icache
//   arb_icache_*             demand read channel to/from the memory arbiter
//   arb_pf_*                 prefetch read channel to/from the memory arbiter
//   stat_hits/stat_misses    buffer hit / demand miss counters (NLP_STATS_EN only)

module next_line_prefetcher #(
    parameter int PF_DISTANCE = 1,   // legal range 1..4
    parameter int LINE_BYTES  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ic_read,
    input  logic [31:0]  ic_address,
    output logic         ic_resp,
    output logic [255:0] ic_rdata,
    output logic         arb_icache_read,
    output logic [31:0]  arb_icache_address,
    input  logic         arb_icache_resp,
    input  logic [255:0] arb_icache_rdata,
    output logic         arb_pf_read,
    output logic [31:0]  arb_pf_address,
    input  logic         arb_pf_resp,
    input  logic [255:0] arb_pf_rdata
`ifdef NLP_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);

    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
    localparam logic [32:0] PF_STRIDE = 33'(PF_DISTANCE * LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HIT    = 3'd1,
        FWD    = 3'd2,
        LAUNCH = 3'd3,
        PF     = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           buf_valid;
    logic [31:0]    buf_tag;
    logic [255:0]   buf_data;
    logic [31:0]    pf_addr;
    logic [31:0]    cur_line;
    logic [31:0]    ic_line;
    logic [32:0]    pf_sum;

    assign ic_line = ic_address & LINE_MASK;
    // Bit 32 flags a prefetch target past the top of the address space.
    assign pf_sum  = {1'b0, cur_line} + PF_STRIDE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        ic_resp            = 1'b0;
        ic_rdata           = '0;
        arb_icache_read    = 1'b0;
        arb_icache_address = '0;
        arb_pf_read        = 1'b0;
        arb_pf_address     = '0;
        case (state_q)
            IDLE: begin
                if (ic_read) begin
                    state_d = (buf_valid && (ic_line == buf_tag)) ? HIT : FWD;
                end
            end
            HIT: begin
                ic_resp  = 1'b1;
                ic_rdata = buf_data;
                state_d  = LAUNCH;
            end
            FWD: begin
                arb_icache_read    = 1'b1;
                arb_icache_address = ic_address;
                ic_resp            = arb_icache_resp;
                ic_rdata           = arb_icache_rdata;
                if (arb_icache_resp) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = pf_sum[32] ? IDLE : PF;
            end
            PF: begin
                // The arbiter cannot abort a granted prefetch, so the request
                // stays up even if the icache wanders off to another line.
                arb_pf_read    = 1'b1;
                arb_pf_address = pf_addr;
                if (arb_pf_resp) begin
                    state_d = (ic_read && (ic_line == pf_addr)) ? HIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            pf_addr   <= '0;
            cur_line  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A miss means the icache left the stream; the buffer is stale.
                    if (state_d == FWD) begin
                        buf_valid <= 1'b0;
                    end
                end
                HIT: begin
                    cur_line  <= buf_tag;
                    buf_valid <= 1'b0;
                end
                FWD: begin
                    if (arb_icache_resp) begin
                        cur_line <= ic_line;
                    end
                end
                LAUNCH: begin
                    pf_addr <= pf_sum[31:0];
                end
                PF: begin
                    if (arb_pf_resp) begin
                        buf_data  <= arb_pf_rdata;
                        buf_tag   <= pf_addr;
                        buf_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NLP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if ((state_q != HIT) && (state_d == HIT) && (stat_hits != 32'hFFFF_FFFF)) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if ((state_q != FWD) && (state_d == FWD) && (stat_misses != 32'hFFFF_FFFF)) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/next_line_prefetcher.md
Name: next_line_prefetcher

Overview:
- Sits between the instruction cache miss port and the memory arbiter's icache and prefetch ports.
- Forwards icache line misses to the arbiter. After each demand fill or buffer hit, it prefetches line N+PF_DISTANCE through the arbiter's prefetch port into a one-line stream buffer.
- A later icache miss that matches the buffered line is answered from the buffer without a memory access.

Parameters:
- PF_DISTANCE, 1: lines ahead of the current line to prefetch; legal range 1..4.
- LINE_BYTES, 32: cacheline size in bytes; address bits [4:0] ignored for line compare.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_read  in  1  icache miss read request, held until ic_resp
- ic_address  in  32  icache miss address
- ic_resp  out  1  one-cycle response to icache
- ic_rdata  out  256  line data to icache, valid when ic_resp=1
- arb_icache_read  out  1  demand read to arbiter
- arb_icache_address  out  32  demand address to arbiter
- arb_icache_resp  in  1  arbiter demand response
- arb_icache_rdata  in  256  arbiter demand data
- arb_pf_read  out  1  prefetch read to arbiter
- arb_pf_address  out  32  prefetch address, line aligned
- arb_pf_resp  in  1  arbiter prefetch response
- arb_pf_rdata  in  256  arbiter prefetch data

Behaviour:
- Reset (synchronous, active-high, rst; clock clk):
  - state=IDLE; buf_valid=0; buf_tag=0; buf_data=0; pf_addr=0.
  - All outputs 0.
  - rst mid-transaction abandons it silently; the arbiter is reset on the same rst.
- Line address: line(a) = {a[31:5],5'b0}.
- IDLE:
  - No ic_read: stay in IDLE.
  - ic_read and buf_valid and line(ic_address)==buf_tag: go to HIT.
  - ic_read otherwise: go to FWD; buf_valid cleared, since the icache is leaving the stream.
- HIT (one cycle):
  - ic_resp=1, ic_rdata=buf_data.
  - cur_line=buf_tag; buf_valid cleared; go to LAUNCH.
  - Hit latency: ic_resp asserts in the second cycle of the request.
- FWD:
  - arb_icache_read=1, arb_icache_address=ic_address.
  - ic_rdata=arb_icache_rdata and ic_resp=arb_icache_resp, combinational passthrough.
  - On arb_icache_resp: cur_line=line(ic_address), go to LAUNCH; otherwise hold.
- LAUNCH (one cycle, no outputs):
  - pf_addr = cur_line + PF_DISTANCE*LINE_BYTES, 33-bit sum.
  - If the sum carries out of bit 31 (wrap past 0xFFFFFFE0): no prefetch, go to IDLE.
  - Otherwise go to PF.
- PF:
  - arb_pf_read=1, arb_pf_address=pf_addr, held constant until arb_pf_resp. The request is never withdrawn, because the arbiter cannot abort a granted prefetch.
  - On arb_pf_resp: buf_data=arb_pf_rdata, buf_tag=pf_addr, buf_valid=1.
  - Then, if ic_read is asserted and line(ic_address)==pf_addr: go to HIT next cycle, served from the freshly written buffer.
  - Otherwise go to IDLE.
- ic_read arriving during PF with a different line: waits, unacknowledged, until the prefetch completes, then is evaluated in IDLE (a miss, so FWD).
- ic_read arriving during HIT/LAUNCH: ignored until IDLE, except that the request driving HIT was already served.
- The icache drops ic_read in the cycle after ic_resp. The block never issues ic_resp twice for one request.
- arb_icache_read and arb_pf_read are never asserted in the same cycle.

Optional Feature:
- Macro: NLP_STATS_EN.
- Defined: adds outputs stat_hits (32) and stat_misses (32).
  - stat_hits increments on entry to HIT; stat_misses increments on entry to FWD.
  - Both reset to 0 on rst and saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Demand miss then prefetch:
  - Stimulus: ic_read at 0x100, arbiter resp after 5 cycles.
  - Required: arb_icache_address=0x100; ic_resp coincident with arb_icache_resp; then arb_pf_read with arb_pf_address=0x120 held until arb_pf_resp.
- Buffer hit:
  - Stimulus: after test 1 completes, ic_read at 0x124.
  - Required: ic_resp=1 in the 2nd cycle with the 0x120 prefetch data; no arb_icache_read; next arb_pf_address=0x140.
- Demand during prefetch, matching:
  - Stimulus: ic_read at 0x120 while PF for 0x120 is outstanding.
  - Required: no arb_icache_read; ic_resp one cycle after arb_pf_resp, with arb_pf_rdata.
- Demand during prefetch, non-matching:
  - Stimulus: ic_read at 0x800 during PF 0x120.
  - Required: arb_pf_read stays high until resp; then FWD to 0x800; buf_valid cleared; next prefetch 0x820.
- Wrap suppression:
  - Stimulus: demand miss at 0xFFFFFFE4.
  - Required: ic_resp occurs; arb_pf_read never asserts; state returns to IDLE.
- Reset mid-PF:
  - Stimulus: rst during PF.
  - Required: next cycle all outputs 0; a subsequent ic_read at 0x120 is treated as a miss.
